// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - shared format codes, opcode fields and immediate limits for instr_enc
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // opcode[6:2]; the low two bits are always 2'b11 for RV32I
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] OP     = 5'b01100;
    localparam logic [4:0] SYSTEM = 5'b11100;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    localparam int ENTRY_W = 33;

endpackage

// File: rtl/instr_enc_sync_fifo.sv
// rtl/instr_enc_sync_fifo.sv - single-clock FIFO holding encoded words for instr_enc
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // an empty FIFO presents zero so stale storage never leaks out
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_enc.sv
// rtl/instr_enc.sv - RV32I instruction field encoder with output FIFO
// Optional immediate range checking enabled by macro INSTR_ENC_IMM_CHECK_EN.
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_sopcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_cnt
);

    logic [6:0]         opcode;
    logic [31:0]        word;
    logic               err;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;

    assign opcode = {in_sopcode, 2'b11};

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (in_fmt)
            FMT_R: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opcode};
            FMT_I: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, opcode};
            FMT_S: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opcode};
            FMT_B: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], opcode};
            FMT_U: word = {in_imm[31:12], in_rd, opcode};
            FMT_J: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
            default: begin
                word = '0;
                err  = 1'b1;
            end
        endcase
`ifdef INSTR_ENC_IMM_CHECK_EN
        // flag values that do not survive truncation; the truncated word is still emitted
        case (in_fmt)
            FMT_I, FMT_S: if ($signed(in_imm) < IMM12_MIN || $signed(in_imm) > IMM12_MAX) err = 1'b1;
            FMT_B: if ($signed(in_imm) < IMM13_MIN || $signed(in_imm) > IMM13_MAX || in_imm[0]) err = 1'b1;
            FMT_J: if ($signed(in_imm) < IMM21_MIN || $signed(in_imm) > IMM21_MAX || in_imm[0]) err = 1'b1;
            FMT_U: if (in_imm[11:0] != 12'd0) err = 1'b1;
            default: ;
        endcase
`endif
    end

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !full || pop;
    assign push      = in_valid && in_ready;
    assign out_instr = head[31:0];
    assign out_err   = head[32];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({err, word}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt <= '0;
        end else if (push) begin
            enc_cnt <= enc_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_enc.sv
// tb/tb_instr_enc.sv - randomized self-checking bench for instr_enc against a field-arithmetic model
module tb_instr_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [4:0]  in_sopcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int model_cnt = 0;
    bit rand_rdy = 0;
    logic [32:0] exp_q [$];

`ifdef INSTR_ENC_IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    instr_enc #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_sopcode (in_sopcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .enc_cnt    (enc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // reference: build the word by shifting each field into place
    function automatic logic [32:0] ref_enc(input int unsigned fmt, sop, rd, rs1, rs2, f3, f7,
                                            input logic [31:0] imm);
        int unsigned w;
        int unsigned op;
        int unsigned u;
        int          s;
        bit          e;
        op = sop * 4 + 3;
        u  = imm;
        s  = $signed(imm);
        e  = 0;
        case (fmt)
            0: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
            1: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((u & 32'hfff) << 20);
            2: w = op + ((u & 31) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
                   + (((u >> 5) & 127) << 25);
            3: w = op + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + (f3 << 12)
                   + (rs1 << 15) + (rs2 << 20) + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
            4: w = op + (rd << 7) + (u & 32'hfffff000);
            5: w = op + (rd << 7) + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20)
                   + (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
            default: begin w = 0; e = 1; end
        endcase
        if (CHK) begin
            case (fmt)
                1, 2: if (s < -2048 || s > 2047) e = 1;
                3:    if (s < -4096 || s > 4094 || (u & 1) != 0) e = 1;
                5:    if (s < -(1 << 20) || s > (1 << 20) - 2 || (u & 1) != 0) e = 1;
                4:    if ((u & 32'hfff) != 0) e = 1;
                default: ;
            endcase
        end
        return {e, w};
    endfunction

    // scoreboard: occupancy/handshake expectations, ordering, and counter
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            check("mon_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
            check("mon_in_ready", {31'b0, in_ready},
                  {31'b0, (exp_q.size() < 4) || (exp_q.size() > 0 && out_ready)});
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_instr", out_instr, e[31:0]);
                check("mon_err", {31'b0, out_err}, {31'b0, e[32]});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_enc(in_fmt, in_sopcode, in_rd, in_rs1, in_rs2,
                                        in_funct3, in_funct7, in_imm));
                model_cnt = (model_cnt + 1) & 16'hffff;
            end
        end
    end

    task automatic drive_req(input int unsigned fmt, sop, rd, rs1, rs2, f3, f7,
                             input logic [31:0] imm);
        in_fmt     = 3'(fmt);
        in_sopcode = 5'(sop);
        in_rd      = 5'(rd);
        in_rs1     = 5'(rs1);
        in_rs2     = 5'(rs2);
        in_funct3  = 3'(f3);
        in_funct7  = 7'(f7);
        in_imm     = imm;
    endtask

    task automatic send(input int unsigned fmt, sop, rd, rs1, rs2, f3, f7,
                        input logic [31:0] imm);
        bit acc;
        acc = 0;
        drive_req(fmt, sop, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rand();
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
            2: imm = 32'($signed($urandom_range(0, 3000000)) - 1500000) & 32'hfffffffe;
            default: imm = $urandom & 32'hfffff000;
        endcase
        send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
             $urandom_range(0, 127), imm);
    endtask

    // single request on an idle FIFO, head inspected while held, then popped
    task automatic expect_one(input string tag, input int unsigned fmt, sop, rd, rs1, rs2, f3,
                              input logic [31:0] imm, input logic [31:0] ei, input bit ee);
        out_ready = 1'b0;
        send(fmt, sop, rd, rs1, rs2, f3, 0, imm);
        @(negedge clk);
        check({tag, "_instr"}, out_instr, ei);
        check({tag, "_err"}, {31'b0, out_err}, {31'b0, ee});
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = !out_valid;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("drain_empty", {31'b0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0, 0, 32'd0);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency: pushed this cycle, visible next cycle
        drive_req(1, 5'b00100, 1, 0, 0, 0, 0, 32'd5);
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", {31'b0, in_ready}, 32'd1);
        check("lat_valid_before", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_after", {31'b0, out_valid}, 32'd1);
        check("lat_instr", out_instr, 32'h00500093);
        check("lat_err", {31'b0, out_err}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        expect_one("sw",   2, 5'b01000, 0, 1, 2, 2, 32'd8, 32'h0020A423, 1'b0);
        expect_one("beq",  3, 5'b11000, 0, 0, 0, 0, -32'sd4, 32'hFE000EE3, 1'b0);
        expect_one("lui",  4, 5'b01101, 5, 0, 0, 0, 32'h12345000, 32'h123452B7, 1'b0);
        expect_one("i2048", 1, 5'b00100, 0, 0, 0, 0, 32'd2048, 32'h80000013, CHK);
        expect_one("jodd", 5, 5'b11011, 0, 0, 0, 0, 32'd3, 32'h0020006F, CHK);
        expect_one("fmt7", 7, 5'b11111, 31, 31, 31, 7, 32'hffffffff, 32'h00000000, 1'b1);
        expect_one("fmt6", 6, 5'b00100, 3, 4, 5, 1, 32'd1, 32'h00000000, 1'b1);

        // backpressure at DEPTH=4, then simultaneous push and pop while full
        for (int i = 0; i < 4; i++) send(1, 5'b00100, i + 1, i, 0, 0, 0, 32'(i * 16));
        @(negedge clk);
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        drive_req(1, 5'b00100, 9, 0, 0, 0, 0, 32'd99);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pushpop_ready", {31'b0, in_ready}, 32'd1);
        check("bp_pushpop_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_still_full", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 drain();

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) send(0, 5'b01100, i, i, i, 0, 0, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_out_instr", out_instr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_one("post_rst", 1, 5'b00100, 1, 0, 0, 0, 32'd5, 32'h00500093, 1'b0);
        check("post_rst_cnt", {16'b0, enc_cnt}, 32'd1);

        // randomized traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) send_rand();
        rand_rdy = 0;
        drain();
        check("rnd_enc_cnt", {16'b0, enc_cnt}, 32'(model_cnt));

        // counter wrap
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send_rand();
        @(negedge clk);
        check("cnt_ffff", {16'b0, enc_cnt}, 32'h0000ffff);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) send_rand();
        @(negedge clk);
        check("cnt_wrap", {16'b0, enc_cnt}, 32'd1);
        @(posedge clk);
        #1 drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have in_valid/in_ready  input/output  1/1  request handshake; transfer when both high.
REQ-005 SHALL have in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-006 SHALL have in_sopcode  input  5  opcode[6:2].
REQ-007 SHALL have in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 SHALL have in_funct3  input  3, and in_funct7  input  7.
REQ-009 SHALL have in_imm  input  32  signed immediate value; for U format this is the full 32-bit value.
REQ-010 SHALL have out_valid/out_ready  output/input  1/1  result handshake.
REQ-011 SHALL have out_instr  output  32  encoded RV32I word, and out_err  output  1  encoding error.
REQ-012 SHALL have enc_cnt  output  16  count of accepted requests.

Function
REQ-013 SHALL set opcode = {in_sopcode, 2'b11}; fields unused by the selected format SHALL be encoded as zero.
REQ-014 Field placement SHALL be:
- I: imm[11:0] at bits [31:20].
- S: imm[11:5] at [31:25], imm[4:0] at [11:7].
- B: imm[12], imm[10:5], imm[4:1], imm[11] at [31], [30:25], [11:8], [7].
- U: imm[31:12] at [31:12].
- J: imm[20], imm[10:1], imm[11], imm[19:12] at [31], [30:21], [20], [19:12].
REQ-015 SHALL push the encoded word and its error flag into the FIFO in the cycle of acceptance; out_valid SHALL rise the following cycle (latency 1).
REQ-016 in_ready SHALL equal (FIFO not full) OR (out_valid AND out_ready); a push and a pop in the same cycle when full SHALL both succeed with the count unchanged.
REQ-017 out_valid SHALL equal (FIFO not empty); out_instr/out_err SHALL show the head entry and SHALL stay stable while out_valid is high and out_ready is low.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-019 enc_cnt SHALL increment on each accepted request and SHALL wrap from 0xFFFF to 0.
REQ-020 Illegal in_fmt SHALL be accepted and SHALL produce out_instr = 0x00000000 with out_err = 1, independent of configuration.

Reset
REQ-021 When rst_n is low: FIFO empty, out_valid = 0, out_err = 0, out_instr = 0, enc_cnt = 0, in_ready = 1.
REQ-022 Reset asserted mid-transfer SHALL discard all FIFO contents; no stale entry SHALL appear after release.

Configuration
REQ-023 With macro INSTR_ENC_IMM_CHECK_EN defined, out_err SHALL be set when any of these holds:
- I/S: in_imm outside [-2048, 2047].
- B: in_imm outside [-4096, 4094], or in_imm[0] = 1.
- J: in_imm outside [-2^20, 2^20-2], or in_imm[0] = 1.
- U: in_imm[11:0] != 0.
In all these cases the truncated word SHALL still be emitted.
REQ-024 Without the macro, out_err SHALL be set only by REQ-020, and out-of-range bits SHALL be silently truncated.

Structure
REQ-025 Format codes (enum), opcode-field constants (LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, OP_IMM, OP, SYSTEM) and immediate range limits SHALL live in the shared definitions package.
REQ-026 The FIFO SHALL be a sub-module named sync_fifo, parameterized by width and DEPTH; encoding logic SHALL be combinational inside instr_enc.

Verification
REQ-027 I-type: fmt=1, sopcode=00100, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093 one cycle later, out_err 0.
REQ-028 S/B/U: sw x2,8(x1) -> 0x0020A423; beq x0,x0,-4 -> 0xFE000EE3; lui x5 with imm 0x12345000 -> 0x123452B7.
REQ-029 Backpressure: DEPTH=4, out_ready=0, push 4 requests -> in_ready 0 after the 4th; then out_ready=1 with in_valid=1 -> push and pop in the same cycle, words emitted in order.
REQ-030 Error: with the macro, fmt=1 and imm=2048 -> out_err 1; fmt=5 and imm=3 -> out_err 1; without the macro both give out_err 0; fmt=7 -> 0x00000000 with out_err 1 in both builds.
REQ-031 Reset with 3 entries queued -> out_valid 0 and enc_cnt 0 immediately (asynchronously); after release the first new request is the first word emitted.
REQ-032 Counter: 65537 accepted requests -> enc_cnt = 1.
